tc_aloader: RTL

Upstream load sequencer for the tensor-core A operand buffer. On `start` it reads the M rows of matrix A from memory, one `DW_MEM`-wide row per request, keeping up to `MAX_OUT` reads in flight. It then drives the buffer write port (`write_en`, `A_input`, `row_in`) one row per cycle as responses arrive, and pulses `done` once every row is resident in the buffer.

---
 rtl/tc_pkg.sv | 21 ++
 rtl/tc_addr_gen.sv | 53 +++++
 rtl/tc_aloader.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/tc_pkg.sv
// Types and helpers shared by the tensor-core operand loaders (A and B).
package tc_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } tc_state_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/tc_addr_gen.sv
// Row address generator: loads base/stride on clear, steps by stride on advance.
module tc_addr_gen
    import tc_pkg::*;
#(
    parameter int unsigned M       = 16,
    parameter int unsigned DW_ADDR = 32,
    localparam int unsigned CntW   = clog2(M + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear_i,
    input  logic               advance_i,
    input  logic [DW_ADDR-1:0] base_addr_i,
    input  logic [DW_ADDR-1:0] row_stride_i,
    output logic [DW_ADDR-1:0] addr_o,
    output logic [CntW-1:0]    req_cnt_o
);

    logic [DW_ADDR-1:0] addr_d, addr_q;
    logic [DW_ADDR-1:0] stride_d, stride_q;
    logic [CntW-1:0]    cnt_d, cnt_q;

    // Address is accumulated rather than multiplied; wraps modulo 2^DW_ADDR.
    always_comb begin
        addr_d   = addr_q;
        stride_d = stride_q;
        cnt_d    = cnt_q;
        if (clear_i) begin
            addr_d   = base_addr_i;
            stride_d = row_stride_i;
            cnt_d    = '0;
        end else if (advance_i) begin
            addr_d = addr_q + stride_q;
            cnt_d  = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            stride_q <= '0;
            cnt_q    <= '0;
        end else begin
            addr_q   <= addr_d;
            stride_q <= stride_d;
            cnt_q    <= cnt_d;
        end
    end

    assign addr_o    = addr_q;
    assign req_cnt_o = cnt_q;

endmodule

// File: rtl/tc_aloader.sv
// A-operand load sequencer: issues M row reads with bounded outstanding count and
// writes each returned row into the operand buffer one cycle after its response.
module tc_aloader
    import tc_pkg::*;
#(
    parameter int unsigned M       = 16,
    parameter int unsigned DW_MEM  = 512,
    parameter int unsigned DW_IDX  = 4,
    parameter int unsigned DW_ADDR = 32,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [DW_ADDR-1:0] base_addr,
    input  logic [DW_ADDR-1:0] row_stride,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [DW_ADDR-1:0] mem_req_addr,
    input  logic               mem_resp_valid,
    input  logic [DW_MEM-1:0]  mem_resp_data,
    output logic               mem_resp_ready,
    output logic               write_en,
    output logic [DW_MEM-1:0]  A_input,
    output logic [DW_IDX-1:0]  row_in
);

    localparam int unsigned OutW = clog2(MAX_OUT + 1);
    localparam int unsigned CntW = clog2(M + 1);

    tc_state_e         state_d, state_q;
    logic [OutW-1:0]   outstanding_d, outstanding_q;
    logic [CntW-1:0]   resp_cnt_d, resp_cnt_q;
    logic              err_d, err_q;
    logic              write_en_d, write_en_q;
    logic [DW_MEM-1:0] a_input_d, a_input_q;
    logic [DW_IDX-1:0] row_in_d, row_in_q;

    logic            gen_clear, gen_advance;
    logic [CntW-1:0] req_cnt;
    logic            req_hs, resp_hs, resp_ok;

    tc_addr_gen #(
        .M       (M),
        .DW_ADDR (DW_ADDR)
    ) u_addr_gen (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (gen_clear),
        .advance_i    (gen_advance),
        .base_addr_i  (base_addr),
        .row_stride_i (row_stride),
        .addr_o       (mem_req_addr),
        .req_cnt_o    (req_cnt)
    );

    assign busy           = (state_q != StIdle);
    assign done           = (state_q == StDone);
    assign err            = err_q;
    assign mem_req_valid  = (state_q == StIssue) && (outstanding_q < OutW'(MAX_OUT));
    assign mem_resp_ready = (state_q == StIssue) || (state_q == StDrain);
    assign write_en       = write_en_q;
    assign A_input        = a_input_q;
    assign row_in         = row_in_q;

    assign req_hs  = mem_req_valid & mem_req_ready;
    assign resp_hs = mem_resp_valid & mem_resp_ready;
    // A response with nothing outstanding is unmatched: flagged, never written.
    assign resp_ok = resp_hs & (outstanding_q != '0);

    always_comb begin
        state_d       = state_q;
        outstanding_d = outstanding_q;
        resp_cnt_d    = resp_cnt_q;
        err_d         = err_q;
        write_en_d    = 1'b0;
        a_input_d     = a_input_q;
        row_in_d      = row_in_q;
        gen_clear     = 1'b0;
        gen_advance   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d       = StIssue;
                    gen_clear     = 1'b1;
                    outstanding_d = '0;
                    resp_cnt_d    = '0;
                    err_d         = 1'b0;
                end
            end
            StIssue: begin
                if (req_hs && (req_cnt == CntW'(M - 1))) state_d = StDrain;
            end
            StDrain: begin
                if (write_en_q && (row_in_q == DW_IDX'(M - 1))) state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if ((state_q == StIssue) || (state_q == StDrain)) begin
            gen_advance = req_hs;
            if (req_hs && !resp_ok) begin
                outstanding_d = outstanding_q + OutW'(1);
            end else if (!req_hs && resp_ok) begin
                outstanding_d = outstanding_q - OutW'(1);
            end
            if (resp_ok) begin
                write_en_d = 1'b1;
                a_input_d  = mem_resp_data;
                row_in_d   = DW_IDX'(resp_cnt_q);
                resp_cnt_d = resp_cnt_q + CntW'(1);
            end else if (resp_hs) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            outstanding_q <= '0;
            resp_cnt_q    <= '0;
            err_q         <= 1'b0;
            write_en_q    <= 1'b0;
            a_input_q     <= '0;
            row_in_q      <= '0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            resp_cnt_q    <= resp_cnt_d;
            err_q         <= err_d;
            write_en_q    <= write_en_d;
            a_input_q     <= a_input_d;
            row_in_q      <= row_in_d;
        end
    end

endmodule
